// File: rtl/mem_rsp_pkg.sv
// Shared types and widths for the byte-SRAM memory responder.
package mem_rsp_pkg;

  localparam int unsigned DATA_W         = 16;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned ADDR_W_DEFAULT = 14;
  localparam int unsigned WAIT_W         = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWrLo,
    StWrHi,
    StRd,
    StRdCap,
    StWait,
    StResp,
    StDrain
  } state_e;

endpackage

// File: rtl/mem_rsp_wait_ctr.sv
// Wait-state down-counter: load a start value, decrement, flag when it reaches zero.
module mem_rsp_wait_ctr
  import mem_rsp_pkg::*;
#(
  parameter int unsigned W = WAIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-interface responder: 16-bit writes as two byte-SRAM writes, byte reads, fixed latency.
// Optional MEM_RESPONDER_STATS_EN adds saturating write/read completion counters.
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datafrommif,
  output logic [BYTE_W-1:0] datatomif,
  output logic              mem_resp,
  output logic              busy,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [BYTE_W-1:0] sram_wdata,
  input  logic [BYTE_W-1:0] sram_rdata
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
`endif
);

  // The counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly WAIT_STATES cycles.
  localparam int unsigned WaitLoadInt = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
  localparam logic [WAIT_W-1:0] WaitLoad = WaitLoadInt[WAIT_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [BYTE_W-1:0] rdata_q;
  logic              capture;
  logic              ctr_load;
  logic              ctr_dec;
  logic              ctr_zero;

  mem_rsp_wait_ctr #(
    .W(WAIT_W)
  ) u_wait_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (ctr_load),
    .load_val(WaitLoad),
    .dec     (ctr_dec),
    .zero    (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    case (state_q)
      StIdle: begin
        if (we) begin
          capture = 1'b1;
          state_d = StWrLo;
        end else if (re) begin
          capture = 1'b1;
          state_d = StRd;
        end
      end
      StWrLo:  state_d = StWrHi;
      StRd:    state_d = StRdCap;
      StWrHi, StRdCap: begin
        if (WAIT_STATES == 0) begin
          state_d = StResp;
        end else begin
          ctr_load = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (ctr_zero) state_d = StResp;
        else          ctr_dec = 1'b1;
      end
      StResp:  state_d = StDrain;
      // Hold here until the requester drops its request so it never issues twice.
      StDrain: if (!re && !we) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      StWrLo: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = addr_q;
        sram_wdata = data_q[BYTE_W-1:0];
      end
      StWrHi: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = addr_q + ADDR_W'(1);
        sram_wdata = data_q[DATA_W-1:BYTE_W];
      end
      StRd: begin
        sram_ce   = 1'b1;
        sram_addr = addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q <= addr;
        data_q <= datafrommif;
      end
      if (state_q == StRdCap) rdata_q <= sram_rdata;
    end
  end

  assign datatomif = rdata_q;
  assign mem_resp  = (state_q == StResp);
  assign busy      = (state_q != StIdle);

`ifdef MEM_RESPONDER_STATS_EN
  logic        is_wr_q;
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_wr_q  <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (capture) is_wr_q <= we;
      if (state_q == StResp) begin
        if (is_wr_q && (wr_cnt_q != 16'hFFFF))  wr_cnt_q <= wr_cnt_q + 16'd1;
        if (!is_wr_q && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench: two responders (WAIT_STATES 2 and 0) share request inputs.
module tb_mem_responder;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          re, we;
  logic [AW-1:0] addr;
  logic [15:0]   wdata_in;

  logic [7:0]    datatomif, datatomif0;
  logic          mem_resp, mem_resp0, busy, busy0;
  logic          sram_ce, sram_we, sram_ce0, sram_we0;
  logic [AW-1:0] sram_addr, sram_addr0;
  logic [7:0]    sram_wdata, sram_wdata0, sram_rdata, sram_rdata0;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0]   wr_cnt, rd_cnt, wr_cnt0, rd_cnt0;
`endif

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .datafrommif(wdata_in),
    .datatomif(datatomif), .mem_resp(mem_resp), .busy(busy), .sram_ce(sram_ce),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef MEM_RESPONDER_STATS_EN
    , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`endif
  );

  mem_responder #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .datafrommif(wdata_in),
    .datatomif(datatomif0), .mem_resp(mem_resp0), .busy(busy0), .sram_ce(sram_ce0),
    .sram_we(sram_we0), .sram_addr(sram_addr0), .sram_wdata(sram_wdata0),
    .sram_rdata(sram_rdata0)
`ifdef MEM_RESPONDER_STATS_EN
    , .wr_cnt(wr_cnt0), .rd_cnt(rd_cnt0)
`endif
  );

  // Synchronous byte SRAM models: read data valid the cycle after the enable.
  logic [7:0] mem  [0:(1<<AW)-1];
  logic [7:0] mem0 [0:(1<<AW)-1];
  int rd_ops  = 0;
  int rd_ops0 = 0;

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else begin
        sram_rdata <= mem[sram_addr];
        rd_ops     <= rd_ops + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (sram_ce0) begin
      if (sram_we0) mem0[sram_addr0] <= sram_wdata0;
      else begin
        sram_rdata0 <= mem0[sram_addr0];
        rd_ops0     <= rd_ops0 + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency = number of clock edges after the sampling edge until the consumer sees mem_resp.
  task automatic xact(input logic w, input logic r, input logic [AW-1:0] a, input logic [15:0] d,
                      input int hold, output int lat, output int lat0, output logic [7:0] rd_resp);
    @(negedge clk);
    we = w; re = r; addr = a; wdata_in = d;
    @(posedge clk);
    #1 addr = ~a; wdata_in = ~d;
    lat = 0; lat0 = 0; rd_resp = '0;
    for (int k = 1; k <= 30 && (lat == 0 || lat0 == 0); k++) begin
      @(negedge clk);
      if (mem_resp && lat == 0) begin
        lat     = k;
        rd_resp = datatomif;
      end
      if (mem_resp0 && lat0 == 0) lat0 = k;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("held_busy", 32'(busy), 1);
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int         lat, lat0, r_before, r0_before;
  logic [7:0] rb;

  initial begin
    reset = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata_in = '0;
    repeat (2) @(negedge clk);
    check("rst_datatomif", 32'(datatomif), 0);
    check("rst_mem_resp",  32'(mem_resp), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_sram_ce",   32'(sram_ce), 0);
    check("rst_sram_addr", 32'(sram_addr), 0);
    check("rst_busy0",     32'(busy0), 0);
    reset = 1'b0;
    @(negedge clk);

    xact(1'b1, 1'b0, 14'h000A, 16'h1234, 0, lat, lat0, rb);
    check("wr_lat",     32'(lat), 5);
    check("wr_lat_ws0", 32'(lat0), 3);
    check("wr_lo",      32'(mem[14'h000A]), 'h34);
    check("wr_hi",      32'(mem[14'h000B]), 'h12);
    check("wr_hi_ws0",  32'(mem0[14'h000B]), 'h12);
    check("wr_idle",    32'(busy), 0);

    xact(1'b0, 1'b1, 14'h000A, 16'h0000, 0, lat, lat0, rb);
    check("rd_lat",       32'(lat), 5);
    check("rd_lat_ws0",   32'(lat0), 3);
    check("rd_at_resp",   32'(rb), 'h34);
    check("rd_hold",      32'(datatomif), 'h34);
    check("rd_hold_ws0",  32'(datatomif0), 'h34);

    xact(1'b1, 1'b0, 14'h3FFF, 16'hBEEF, 0, lat, lat0, rb);
    check("wrap_lo",      32'(mem[14'h3FFF]), 'hEF);
    check("wrap_hi",      32'(mem[14'h0000]), 'hBE);
    check("wr_keeps_rd",  32'(datatomif), 'h34);

    r_before = rd_ops; r0_before = rd_ops0;
    xact(1'b0, 1'b1, 14'h0000, 16'h0000, 10, lat, lat0, rb);
    check("held_one_read",     32'(rd_ops - r_before), 1);
    check("held_one_read_ws0", 32'(rd_ops0 - r0_before), 1);
    check("held_data",         32'(rb), 'hBE);
    check("held_released",     32'(busy), 0);

    xact(1'b1, 1'b1, 14'h0020, 16'hA5C3, 0, lat, lat0, rb);
    check("both_lo",   32'(mem[14'h0020]), 'hC3);
    check("both_hi",   32'(mem[14'h0021]), 'hA5);
    check("both_lat",  32'(lat), 5);
    check("both_keep", 32'(datatomif), 'hBE);

    xact(1'b0, 1'b1, 14'h3FFF, 16'h0000, 0, lat, lat0, rb);
    check("rd_wrap_addr", 32'(rb), 'hEF);

    xact(1'b1, 1'b0, 14'h0100, 16'h5566, 0, lat, lat0, rb);
    check("pre_hi", 32'(mem[14'h0101]), 'h55);

`ifdef MEM_RESPONDER_STATS_EN
    check("wr_cnt",  32'(wr_cnt), 4);
    check("rd_cnt",  32'(rd_cnt), 3);
    check("wr_cnt0", 32'(wr_cnt0), 4);
    check("rd_cnt0", 32'(rd_cnt0), 3);
`endif

    // Reset while the high byte is being written.
    @(negedge clk);
    we = 1'b1; addr = 14'h0100; wdata_in = 16'h7788;
    @(posedge clk);
    @(negedge clk);
    check("wrlo_addr",  32'(sram_addr), 'h100);
    check("wrlo_wdata", 32'(sram_wdata), 'h88);
    @(negedge clk);
    check("wrhi_we",    32'(sram_we), 1);
    check("wrhi_addr",  32'(sram_addr), 'h101);
    check("wrhi_wdata", 32'(sram_wdata), 'h77);
    reset = 1'b1;
    #1;
    check("arst_sram_ce",    32'(sram_ce), 0);
    check("arst_sram_we",    32'(sram_we), 0);
    check("arst_sram_addr",  32'(sram_addr), 0);
    check("arst_sram_wdata", 32'(sram_wdata), 0);
    check("arst_busy",       32'(busy), 0);
    check("arst_datatomif",  32'(datatomif), 0);
    check("arst_sram_we0",   32'(sram_we0), 0);
    we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_lo_written",  32'(mem[14'h0100]), 'h88);
    check("arst_hi_untouched", 32'(mem[14'h0101]), 'h55);
    check("arst_idle",        32'(busy), 0);
    check("arst_no_resp",     32'(mem_resp), 0);
`ifdef MEM_RESPONDER_STATS_EN
    check("arst_wr_cnt", 32'(wr_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
